// File: rtl/inst_rom_bank_pkg.sv
// Shared definitions for the instruction ROM bank: fill words, controller states
// and the fetch-data source select.
package inst_rom_bank_pkg;

    localparam logic [31:0] NOP_WORD  = 32'h0000_0013;
    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_PROG  = 2'd2
    } rom_state_t;

    // Which value the fetch data output presents until the next accepted fetch.
    typedef enum logic [1:0] {
        SRC_NONE = 2'd0,
        SRC_RAM  = 2'd1,
        SRC_FILL = 2'd2
    } fetch_src_t;

    function automatic logic word_aligned(input logic [1:0] lsb);
        return lsb == 2'b00;
    endfunction

endpackage

// File: rtl/inst_rom_bank_ram.sv
// Simple dual-port synchronous RAM: one write port, one registered read port.
// No reset on storage or read data so it maps onto block RAM.
module inst_rom_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4096,
    localparam int IDX_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_waddr,
    input  logic [DATA_W-1:0] i_wdata,
    input  logic              i_re,
    input  logic [IDX_W-1:0]  i_raddr,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rdata_p1;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata_p1 <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata_p1;

endmodule

// File: rtl/inst_rom_bank.sv
// Instruction memory with a post-reset fill sweep, a 1-cycle fetch port and a
// burst programming port that owns the write side while a session is open.
module inst_rom_bank
    import inst_rom_bank_pkg::*;
#(
    parameter int                DATA_W    = 32,
    parameter int                ADDR_W    = 32,
    parameter int                DEPTH     = 4096,
    parameter logic [DATA_W-1:0] FILL_WORD = DATA_W'(NOP_WORD),
    localparam int               IDX_W     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    output logic              fetch_ready,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    output logic              fetch_err,
    input  logic              prog_start,
    input  logic [ADDR_W-1:0] prog_base,
    input  logic              prog_valid,
    input  logic [DATA_W-1:0] prog_data,
    input  logic              prog_last,
    output logic              prog_ready,
    output logic              prog_busy,
    output logic              prog_err,
    output logic [IDX_W:0]    prog_count
);

    localparam logic [ADDR_W-3:0] DEPTH_A = (ADDR_W-2)'(DEPTH);
    localparam logic [IDX_W:0]    DEPTH_X = (IDX_W+1)'(DEPTH);
    localparam logic [IDX_W:0]    LAST_X  = (IDX_W+1)'(DEPTH - 1);

    rom_state_t        r_state;
    rom_state_t        w_state_nxt;
    logic [IDX_W:0]    r_widx;
    logic [IDX_W:0]    r_prog_count;
    logic              r_prog_err;

    logic              w_fetch_acc;
    logic              w_fetch_ok;
    logic              w_base_ok;
    logic              w_widx_ok;
    logic              w_ram_we;
    logic [DATA_W-1:0] w_ram_wdata;
    logic [DATA_W-1:0] w_ram_rdata;

    logic              r_fetch_vld_p1;
    logic              r_fetch_err_p1;
    fetch_src_t        r_fetch_src_p1;

    assign w_fetch_ok  = word_aligned(fetch_addr[1:0]) && (fetch_addr[ADDR_W-1:2] < DEPTH_A);
    assign w_base_ok   = word_aligned(prog_base[1:0])  && (prog_base[ADDR_W-1:2]  < DEPTH_A);
    assign w_widx_ok   = r_widx < DEPTH_X;
    assign w_fetch_acc = fetch_req && (r_state == ST_RUN);

    // The write port is owned by the fill sweep in CLEAR and by the loader in PROG.
    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_wdata = prog_data;
        case (r_state)
            ST_CLEAR: begin
                w_ram_we    = 1'b1;
                w_ram_wdata = FILL_WORD;
                if (r_widx == LAST_X) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (prog_start && w_base_ok) begin
                    w_state_nxt = ST_PROG;
                end
            end
            ST_PROG: begin
                if (prog_valid) begin
                    w_ram_we = w_widx_ok;
                    if (prog_last) begin
                        w_state_nxt = ST_RUN;
                    end
                end
            end
            default: w_state_nxt = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // One counter serves as sweep index in CLEAR and as write index in PROG.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_widx       <= '0;
            r_prog_count <= '0;
            r_prog_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    r_widx <= (r_widx == LAST_X) ? '0 : r_widx + 1'b1;
                end
                ST_RUN: begin
                    if (prog_start) begin
                        if (w_base_ok) begin
                            r_widx       <= {1'b0, prog_base[IDX_W+1:2]};
                            r_prog_count <= '0;
                            r_prog_err   <= 1'b0;
                        end else begin
                            r_prog_err   <= 1'b1;
                        end
                    end
                end
                ST_PROG: begin
                    if (prog_valid) begin
                        if (w_widx_ok) begin
                            r_widx       <= r_widx + 1'b1;
                            r_prog_count <= r_prog_count + 1'b1;
                        end else begin
                            r_prog_err   <= 1'b1;
                        end
                    end
                end
                default: r_widx <= '0;
            endcase
        end
    end

    inst_rom_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_waddr (r_widx[IDX_W-1:0]),
        .i_wdata (w_ram_wdata),
        .i_re    (w_fetch_acc && w_fetch_ok),
        .i_raddr (fetch_addr[IDX_W+1:2]),
        .o_rdata (w_ram_rdata)
    );

    // ---- fetch stage p0 -> p1: RAM read and error/source capture ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetch_vld_p1 <= 1'b0;
            r_fetch_err_p1 <= 1'b0;
            r_fetch_src_p1 <= SRC_NONE;
        end else begin
            r_fetch_vld_p1 <= w_fetch_acc;
            r_fetch_err_p1 <= w_fetch_acc && !w_fetch_ok;
            if (w_fetch_acc) begin
                r_fetch_src_p1 <= w_fetch_ok ? SRC_RAM : SRC_FILL;
            end
        end
    end

    // The RAM only reads on accepted in-range fetches, so its output holds between them.
    always_comb begin
        fetch_data = DATA_W'(ZERO_WORD);
        case (r_fetch_src_p1)
            SRC_RAM:  fetch_data = w_ram_rdata;
            SRC_FILL: fetch_data = FILL_WORD;
            default:  fetch_data = DATA_W'(ZERO_WORD);
        endcase
    end

    assign fetch_ready = (r_state == ST_RUN);
    assign fetch_valid = r_fetch_vld_p1;
    assign fetch_err   = r_fetch_err_p1;
    assign prog_ready  = (r_state == ST_PROG);
    assign prog_busy   = (r_state != ST_RUN);
    assign prog_err    = r_prog_err;
    assign prog_count  = r_prog_count;

endmodule

// File: tb/tb_inst_rom_bank.sv
// Self-checking bench for inst_rom_bank with DEPTH=16: directed tables and
// sequences plus randomized fetches and sessions against a memory-array model.
module tb_inst_rom_bank;

    localparam int          DATA_W = 32;
    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 16;
    localparam int          IDX_W  = 4;
    localparam logic [31:0] FILL   = 32'h0000_0013;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              fetch_req;
    logic [ADDR_W-1:0] fetch_addr;
    logic              fetch_ready;
    logic              fetch_valid;
    logic [DATA_W-1:0] fetch_data;
    logic              fetch_err;
    logic              prog_start;
    logic [ADDR_W-1:0] prog_base;
    logic              prog_valid;
    logic [DATA_W-1:0] prog_data;
    logic              prog_last;
    logic              prog_ready;
    logic              prog_busy;
    logic              prog_err;
    logic [IDX_W:0]    prog_count;

    always #5 clk = ~clk;

    inst_rom_bank #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .DEPTH     (DEPTH),
        .FILL_WORD (FILL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_ready (fetch_ready),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .fetch_err   (fetch_err),
        .prog_start  (prog_start),
        .prog_base   (prog_base),
        .prog_valid  (prog_valid),
        .prog_data   (prog_data),
        .prog_last   (prog_last),
        .prog_ready  (prog_ready),
        .prog_busy   (prog_busy),
        .prog_err    (prog_err),
        .prog_count  (prog_count)
    );

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        logic        err;
    } vec_t;

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] m_mem [DEPTH];
    logic        m_err;
    int          m_count;
    logic [31:0] last_data;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_mem[i] = FILL;
        m_err   = 1'b0;
        m_count = 0;
    endtask

    function automatic logic addr_ok(input logic [31:0] a);
        return (a % 4 == 0) && (a / 4 < DEPTH);
    endfunction

    task automatic model_fetch(input logic [31:0] a, output logic [31:0] d, output logic e);
        if (addr_ok(a)) begin
            d = m_mem[int'(a / 4)];
            e = 1'b0;
        end else begin
            d = FILL;
            e = 1'b1;
        end
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_fvld"},  fetch_valid, 0);
        chk({nm, "_fdata"}, fetch_data,  0);
        chk({nm, "_ferr"},  fetch_err,   0);
        chk({nm, "_frdy"},  fetch_ready, 0);
        chk({nm, "_prdy"},  prog_ready,  0);
        chk({nm, "_busy"},  prog_busy,   1);
        chk({nm, "_perr"},  prog_err,    0);
        chk({nm, "_pcnt"},  prog_count,  0);
    endtask

    task automatic wait_clear(input string nm);
        int cnt = 0;
        while (prog_busy && cnt < 100) begin
            step();
            cnt++;
        end
        chk({nm, "_clear_cycles"}, cnt, DEPTH);
        chk({nm, "_frdy_after"}, fetch_ready, 1);
    endtask

    // Back-to-back fetches from a table; one result per cycle.
    task automatic run_table(input string nm, input vec_t tbl[$]);
        foreach (tbl[i]) begin
            fetch_req  = 1'b1;
            fetch_addr = tbl[i].addr;
            step();
            chk($sformatf("%s[%0d]_vld", nm, i),  fetch_valid, 1);
            chk($sformatf("%s[%0d]_data", nm, i), fetch_data,  tbl[i].data);
            chk($sformatf("%s[%0d]_err", nm, i),  fetch_err,   tbl[i].err);
            last_data = tbl[i].data;
        end
        fetch_req = 1'b0;
        step();
        chk({nm, "_idle_vld"},  fetch_valid, 0);
        chk({nm, "_idle_err"},  fetch_err,   0);
        chk({nm, "_idle_hold"}, fetch_data,  last_data);
    endtask

    task automatic fetch_one(input logic [31:0] a, input string nm);
        logic [31:0] d;
        logic        e;
        model_fetch(a, d, e);
        fetch_req  = 1'b1;
        fetch_addr = a;
        step();
        fetch_req = 1'b0;
        chk({nm, "_vld"},  fetch_valid, 1);
        chk({nm, "_data"}, fetch_data,  d);
        chk({nm, "_err"},  fetch_err,   e);
    endtask

    // Programming session; optional fetch held high through it (starting in the prog_start cycle).
    task automatic session(input logic [31:0] base, input int nbeats, input logic [31:0] d0,
                           input bit rnd, input bit fetch_during, input string nm);
        int          widx;
        logic [31:0] fd;
        logic        fe;
        if (fetch_during) begin
            model_fetch(32'h8, fd, fe);
            fetch_req  = 1'b1;
            fetch_addr = 32'h8;
        end
        prog_start = 1'b1;
        prog_base  = base;
        step();
        prog_start = 1'b0;
        if (fetch_during) begin
            chk({nm, "_start_fvld"},  fetch_valid, 1);
            chk({nm, "_start_fdata"}, fetch_data,  fd);
        end
        if (!addr_ok(base)) begin
            m_err = 1'b1;
            chk({nm, "_bad_busy"}, prog_busy,  0);
            chk({nm, "_bad_err"},  prog_err,   m_err);
            chk({nm, "_bad_cnt"},  prog_count, m_count);
            fetch_req = 1'b0;
            return;
        end
        m_err   = 1'b0;
        m_count = 0;
        widx    = int'(base / 4);
        chk({nm, "_busy"},  prog_busy,  1);
        chk({nm, "_cnt0"},  prog_count, 0);
        for (int i = 0; i < nbeats; i++) begin
            logic [31:0] d;
            d = rnd ? $urandom : d0 + 32'(i);
            chk($sformatf("%s_b%0d_prdy", nm, i), prog_ready,  1);
            chk($sformatf("%s_b%0d_frdy", nm, i), fetch_ready, 0);
            prog_valid = 1'b1;
            prog_data  = d;
            prog_last  = (i == nbeats - 1);
            step();
            if (widx < DEPTH) begin
                m_mem[widx] = d;
                widx++;
                m_count++;
            end else begin
                m_err = 1'b1;
            end
            if (fetch_during) chk($sformatf("%s_b%0d_fvld", nm, i), fetch_valid, 0);
        end
        prog_valid = 1'b0;
        prog_last  = 1'b0;
        chk({nm, "_end_busy"}, prog_busy,  0);
        chk({nm, "_end_err"},  prog_err,   m_err);
        chk({nm, "_end_cnt"},  prog_count, m_count);
        if (fetch_during) begin
            model_fetch(32'h8, fd, fe);
            chk({nm, "_end_frdy"}, fetch_ready, 1);
            chk({nm, "_end_fvld"}, fetch_valid, 0);
            step();
            fetch_req = 1'b0;
            chk({nm, "_resume_fvld"},  fetch_valid, 1);
            chk({nm, "_resume_fdata"}, fetch_data,  fd);
        end
    endtask

    initial begin
        vec_t tbl[$];
        rst_n      = 1'b0;
        fetch_req  = 1'b0;
        fetch_addr = '0;
        prog_start = 1'b0;
        prog_base  = '0;
        prog_valid = 1'b0;
        prog_data  = '0;
        prog_last  = 1'b0;
        model_reset();
        step();
        step();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        wait_clear("t1");

        // Full sweep readback plus misaligned / out-of-range entries.
        for (int i = 0; i < DEPTH; i++) tbl.push_back('{32'(i * 4), FILL, 1'b0});
        tbl.push_back('{32'h6,  FILL, 1'b1});
        tbl.push_back('{32'h40, FILL, 1'b1});
        tbl.push_back('{32'h0,  FILL, 1'b0});
        run_table("t1_sweep", tbl);

        session(32'h8, 2, 32'hAAAA_0001, 1'b0, 1'b0, "t2");
        chk("t2_count_const", prog_count, 2);
        tbl.delete();
        tbl.push_back('{32'h8,  32'hAAAA_0001, 1'b0});
        tbl.push_back('{32'hC,  32'hAAAA_0002, 1'b0});
        tbl.push_back('{32'h10, FILL,          1'b0});
        tbl.push_back('{32'h6,  FILL,          1'b1});
        tbl.push_back('{32'h40, FILL,          1'b1});
        run_table("t2_rb", tbl);

        session(32'h38, 3, 32'hBBBB_0001, 1'b0, 1'b0, "t4");
        chk("t4_err_const",   prog_err,   1);
        chk("t4_count_const", prog_count, 2);
        fetch_one(32'h38, "t4_rd38");
        fetch_one(32'h3C, "t4_rd3c");

        session(32'h4, 3, 32'hCCCC_0001, 1'b0, 1'b1, "t5");
        session(32'h2,  1, 32'h0, 1'b1, 1'b0, "t_badmis");
        session(32'h40, 1, 32'h0, 1'b1, 1'b0, "t_badrng");

        // Randomized fetches and sessions against the model.
        for (int it = 0; it < 150; it++) begin
            int sel;
            sel = int'($urandom_range(0, 9));
            if (sel < 7) begin
                logic [31:0] a;
                a = (sel < 5) ? 32'($urandom_range(0, DEPTH - 1) * 4) : 32'($urandom_range(0, 79));
                fetch_one(a, $sformatf("rnd%0d_f", it));
            end else begin
                logic [31:0] b;
                b = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 79))
                                                 : 32'($urandom_range(0, DEPTH + 1) * 4);
                session(b, int'($urandom_range(1, 4)), 32'h0, 1'b1, 1'b0,
                        $sformatf("rnd%0d_s", it));
            end
        end

        // Asynchronous reset in the middle of an open session.
        prog_start = 1'b1;
        prog_base  = 32'h0;
        step();
        prog_start = 1'b0;
        prog_valid = 1'b1;
        prog_data  = 32'hDEAD_BEEF;
        step();
        chk("t6_in_prog", prog_busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        prog_valid = 1'b0;
        model_reset();
        step();
        rst_n = 1'b1;
        wait_clear("t6");
        tbl.delete();
        for (int i = 0; i < DEPTH; i++) tbl.push_back('{32'(i * 4), FILL, 1'b0});
        run_table("t6_refill", tbl);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, %0d checks so far", n_chk);
        $fatal(1, "timeout");
    end

endmodule
